// File: rtl/hs_pkg.sv
// Shared types and constants for the high-score controller and its BCD converter.
package hs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StInsert,
        StShow
    } hs_state_e;

    localparam logic [1:0] RANK_SELF  = 2'd0;
    localparam logic [1:0] RANK_ONE   = 2'd1;
    localparam logic [1:0] RANK_TWO   = 2'd2;
    localparam logic [1:0] RANK_THREE = 2'd3;

    localparam int unsigned BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_convert.sv
// Sequential shift-add-3 binary-to-BCD converter; done pulses SCORE_W+1 cycles after start.
module bcd_convert
    import hs_pkg::*;
#(
    parameter int unsigned SCORE_W = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [SCORE_W-1:0]      bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int unsigned BcdW = 4 * BCD_DIGITS;
    localparam int unsigned ShW  = BcdW + SCORE_W;
    localparam int unsigned CntW = $clog2(SCORE_W + 1);

    logic [ShW-1:0]  sh_q, sh_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [BcdW-1:0] adj;
    logic [3:0]      nib;

    // Add-3 correction on every BCD nibble before the next shift.
    always_comb begin
        adj = '0;
        nib = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            nib           = sh_q[SCORE_W + 4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (!busy_q) begin
            if (start_i) begin
                sh_d   = {{BcdW{1'b0}}, bin_i};
                cnt_d  = '0;
                busy_d = 1'b1;
            end
        end else if (cnt_q == CntW'(SCORE_W)) begin
            busy_d = 1'b0;
        end else begin
            sh_d  = {adj, sh_q[SCORE_W-1:0]} << 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CntW'(SCORE_W));
    assign bcd_o  = sh_q[ShW-1 -: BcdW];

endmodule

// File: rtl/highscore_ctrl.sv
// Snake score sequencer: live score, top-3 table, displayed-rank select and BCD digit drive.
// Build option HS_AUTO_CYCLE_EN: in SHOW the rank also advances every CYCLE_TICKS tick pulses.
module highscore_ctrl
    import hs_pkg::*;
#(
    parameter int unsigned SCORE_W     = 11,
    parameter int unsigned CYCLE_TICKS = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       game_start_i,
    input  logic       game_over_i,
    input  logic       score_inc_i,
    input  logic       next_rank_i,
    input  logic       tick_i,
    output logic [1:0] rank_sel_o,
    output logic [3:0] dig0_o,
    output logic [3:0] dig1_o,
    output logic [3:0] dig2_o,
    output logic [3:0] dig3_o,
    output logic       new_record_o,
    output logic       busy_o
);

    localparam int unsigned        BcdW     = 4 * BCD_DIGITS;
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    hs_state_e          state_q, state_d;
    logic [SCORE_W-1:0] cur_q, cur_d, first_q, first_d, second_q, second_d, third_q, third_d;
    logic [1:0]         rank_q, rank_d;
    logic               new_record_q, new_record_d;
    logic               rank_adv;

`ifdef HS_AUTO_CYCLE_EN
    localparam int unsigned TickW = $clog2(CYCLE_TICKS + 1);

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick_expire;

    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        tick_expire = 1'b0;
        if (state_q != StShow) begin
            tick_cnt_d = '0;
        end else begin
            if (tick_i) begin
                if (tick_cnt_q == TickW'(CYCLE_TICKS - 1)) begin
                    tick_expire = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            if (tick_expire || next_rank_i) begin
                tick_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign rank_adv = next_rank_i || tick_expire;
`else
    logic unused_tick;
    assign unused_tick = tick_i ^ CYCLE_TICKS[0];
    assign rank_adv    = next_rank_i;
`endif

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        first_d      = first_q;
        second_d     = second_q;
        third_d      = third_q;
        rank_d       = rank_q;
        new_record_d = new_record_q;
        unique case (state_q)
            StIdle, StShow: begin
                if (game_start_i) begin
                    state_d      = StPlay;
                    cur_d        = '0;
                    new_record_d = 1'b0;
                    rank_d       = RANK_SELF;
                end else if (state_q == StShow && rank_adv) begin
                    rank_d = rank_q + 2'd1;
                end
            end
            StPlay: begin
                rank_d = RANK_SELF;
                if (score_inc_i && cur_q != ScoreMax) begin
                    cur_d = cur_q + 1'b1;
                end
                if (game_over_i) begin
                    state_d = StInsert;
                end
            end
            StInsert: begin
                state_d = StShow;
                rank_d  = RANK_ONE;
                // Strictly greater: a tie never displaces an existing entry.
                if (cur_q > first_q) begin
                    third_d      = second_q;
                    second_d     = first_q;
                    first_d      = cur_q;
                    new_record_d = 1'b1;
                end else if (cur_q > second_q) begin
                    third_d  = second_q;
                    second_d = cur_q;
                end else if (cur_q > third_q) begin
                    third_d = cur_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Display path: any change of the shown value or rank queues one (coalesced) conversion.
    logic [SCORE_W-1:0] disp_val, last_val_q;
    logic [1:0]         last_rank_q;
    logic               req, pend_q, pend_d;
    logic               conv_start, conv_busy, conv_done;
    logic [BcdW-1:0]    conv_bcd, dig_q;

    always_comb begin
        unique case (rank_q)
            RANK_SELF: disp_val = cur_q;
            RANK_ONE:  disp_val = first_q;
            RANK_TWO:  disp_val = second_q;
            default:   disp_val = third_q;
        endcase
    end

    assign req        = (disp_val != last_val_q) || (rank_q != last_rank_q);
    assign conv_start = pend_q && !conv_busy;
    assign pend_d     = conv_start ? 1'b0 : (pend_q || req);

    bcd_convert #(
        .SCORE_W (SCORE_W)
    ) u_bcd_convert (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (conv_start),
        .bin_i   (disp_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            first_q      <= '0;
            second_q     <= '0;
            third_q      <= '0;
            rank_q       <= RANK_SELF;
            new_record_q <= 1'b0;
            last_val_q   <= '0;
            last_rank_q  <= RANK_SELF;
            pend_q       <= 1'b0;
            dig_q        <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            first_q      <= first_d;
            second_q     <= second_d;
            third_q      <= third_d;
            rank_q       <= rank_d;
            new_record_q <= new_record_d;
            last_val_q   <= disp_val;
            last_rank_q  <= rank_q;
            pend_q       <= pend_d;
            if (conv_done) begin
                dig_q <= conv_bcd;
            end
        end
    end

    assign rank_sel_o   = rank_q;
    assign new_record_o = new_record_q;
    assign busy_o       = conv_busy;
    assign dig0_o       = dig_q[3:0];
    assign dig1_o       = dig_q[7:4];
    assign dig2_o       = dig_q[11:8];
    assign dig3_o       = dig_q[15:12];

endmodule
